// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared register-file constants, the write-arbiter state
//               encoding, and a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // Arbiter state: fixed writeback priority, or one forced multicycle grant
    typedef enum logic [0:0] {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_t;

    // Decode a register address into a one-hot register mask
    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        return REG_COUNT'(1) << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_busy_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_busy_scoreboard
// Description : One busy bit per register, set when a multicycle op reserves
//               the register and cleared when its result is accepted.
//               A same-cycle set wins over a clear; register 0 is never busy.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_busy_scoreboard
    import mips_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_address,
    input  logic                  clear_valid,
    input  logic [REG_ADDR_W-1:0] clear_address,
    output logic [REG_COUNT-1:0]  busy_mask
);

    // Register 0 is hardwired to zero, so it can never await a result
    localparam logic [REG_COUNT-1:0] c_reg0_clear = ~REG_COUNT'(1);

    logic [REG_COUNT-1:0] w_set;
    logic [REG_COUNT-1:0] w_clear;
    logic [REG_COUNT-1:0] w_next;

    // Next mask: clear first, then set, so a same-cycle reserve survives
    always_comb begin
        w_set   = set_valid   ? reg_onehot(set_address)   : '0;
        w_clear = clear_valid ? reg_onehot(clear_address) : '0;
        w_next  = ((busy_mask & ~w_clear) | w_set) & c_reg0_clear;
    end

    // Mask register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register-file write port between writeback
//               (fixed priority) and the multicycle unit. A wait counter
//               forces one multicycle grant after MAX_WAIT denied cycles.
//               Also tracks destinations reserved by in-flight multicycle ops.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_address,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  wb_stall,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_address,
    input  logic [DATA_W-1:0]     mc_data,
    output logic                  mc_ready,
    input  logic                  mc_reserve_valid,
    input  logic [REG_ADDR_W-1:0] mc_reserve_address,
    output logic [REG_COUNT-1:0]  busy_mask,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0]     rf_write_data
);

    localparam int                 c_cnt_w    = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_max_wait = c_cnt_w'(MAX_WAIT);

    arb_state_t          r_state;
    logic [c_cnt_w-1:0]  r_wait_count;

    logic                w_force;
    logic                w_wb_grant;
    logic                w_mc_handshake;
    logic [c_cnt_w-1:0]  w_count_inc;

    // Grant decode: writeback wins in NORMAL, multicycle owns the port in FORCE
    always_comb begin
        w_force        = (r_state == ARB_FORCE);
        mc_ready       = w_force | ~wb_valid;
        wb_stall       = w_force & wb_valid;
        w_wb_grant     = wb_valid & ~w_force;
        w_mc_handshake = mc_valid & mc_ready;
        w_count_inc    = (r_wait_count == c_max_wait) ? r_wait_count
                                                      : r_wait_count + c_cnt_w'(1);
    end

    // Arbiter FSM and starvation counter; FORCE always lasts a single cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ARB_NORMAL;
            r_wait_count <= '0;
        end else begin
            case (r_state)
                ARB_FORCE: begin
                    r_state      <= ARB_NORMAL;
                    r_wait_count <= '0;
                end
                default: begin
                    if (mc_valid && !mc_ready) begin
                        r_wait_count <= w_count_inc;
                        if (w_count_inc == c_max_wait) begin
                            r_state <= ARB_FORCE;
                        end
                    end else begin
                        r_wait_count <= '0;
                    end
                end
            endcase
        end
    end

    // Write-port registers; a write to register 0 is consumed but not enabled
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_write_enable  <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
        end else if (w_wb_grant) begin
            rf_write_enable  <= (wb_address != '0);
            rf_write_address <= wb_address;
            rf_write_data    <= wb_data;
        end else if (w_mc_handshake) begin
            rf_write_enable  <= (mc_address != '0);
            rf_write_address <= mc_address;
            rf_write_data    <= mc_data;
        end else begin
            rf_write_enable  <= 1'b0;
        end
    end

    regfile_busy_scoreboard u_busy_scoreboard (
        .clock         (clock),
        .reset         (reset),
        .set_valid     (mc_reserve_valid),
        .set_address   (mc_reserve_address),
        .clear_valid   (w_mc_handshake),
        .clear_address (mc_address),
        .busy_mask     (busy_mask)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench: directed scenarios followed by random
//               traffic, compared against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_address = '0;
    logic [31:0] wb_data = '0;
    logic        wb_stall;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_address = '0;
    logic [31:0] mc_data = '0;
    logic        mc_ready;
    logic        mc_reserve_valid = 1'b0;
    logic [4:0]  mc_reserve_address = '0;
    logic [31:0] busy_mask;
    logic        rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock              (clock),
        .reset              (reset),
        .wb_valid           (wb_valid),
        .wb_address         (wb_address),
        .wb_data            (wb_data),
        .wb_stall           (wb_stall),
        .mc_valid           (mc_valid),
        .mc_address         (mc_address),
        .mc_data            (mc_data),
        .mc_ready           (mc_ready),
        .mc_reserve_valid   (mc_reserve_valid),
        .mc_reserve_address (mc_reserve_address),
        .busy_mask          (busy_mask),
        .rf_write_enable    (rf_write_enable),
        .rf_write_address   (rf_write_address),
        .rf_write_data      (rf_write_data)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: consecutive denied cycles, per-register busy flags,
    // and the expected contents of the write-port registers.
    int          m_waited = 0;
    bit          m_busy [32];
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          m_last_hs = 1'b0;

    function automatic logic [31:0] busy_word();
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 32; b++) w[b] = m_busy[b];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: check registered outputs, apply inputs, check the
    // combinational handshake outputs, then advance the model.
    task automatic step(input bit rst,
                        input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                        input bit mv, input logic [4:0] ma, input logic [31:0] md,
                        input bit rv, input logic [4:0] ra);
        bit force_now, exp_ready, exp_stall, hs, wgr;
        @(posedge clock);
        #1;
        chk("rf_write_enable",  32'(rf_write_enable),  32'(m_we));
        chk("rf_write_address", 32'(rf_write_address), 32'(m_addr));
        chk("rf_write_data",    rf_write_data,         m_data);
        chk("busy_mask",        busy_mask,             busy_word());
        reset              = rst;
        wb_valid           = wv;
        wb_address         = wa;
        wb_data            = wd;
        mc_valid           = mv;
        mc_address         = ma;
        mc_data            = md;
        mc_reserve_valid   = rv;
        mc_reserve_address = ra;
        #1;
        force_now = (m_waited >= MAX_WAIT);
        exp_ready = force_now || !wv;
        exp_stall = force_now && wv;
        chk("mc_ready", 32'(mc_ready), 32'(exp_ready));
        chk("wb_stall", 32'(wb_stall), 32'(exp_stall));
        if (rst) begin
            m_waited = 0;
            for (int b = 0; b < 32; b++) m_busy[b] = 1'b0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
            m_last_hs = 1'b0;
        end else begin
            hs  = mv && exp_ready;
            wgr = wv && !force_now;
            if (wgr) begin
                m_we = (wa != 0); m_addr = wa; m_data = wd;
            end else if (hs) begin
                m_we = (ma != 0); m_addr = ma; m_data = md;
            end else begin
                m_we = 1'b0;
            end
            if (hs) m_busy[ma] = 1'b0;
            if (rv && ra != 0) m_busy[ra] = 1'b1;
            if (force_now)       m_waited = 0;
            else if (mv && !hs)  m_waited = m_waited + 1;
            else                 m_waited = 0;
            m_last_hs = hs;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    initial begin
        bit          r;
        bit          pend;
        logic [4:0]  pa;
        logic [31:0] pd;
        for (int b = 0; b < 32; b++) m_busy[b] = 1'b0;

        // Reset and post-reset idle state
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        idle();
        chk("reset_we",       32'(rf_write_enable), 32'd0);
        chk("reset_busy",     busy_mask,            32'd0);
        chk("reset_mc_ready", 32'(mc_ready),        32'd1);
        chk("reset_wb_stall", 32'(wb_stall),        32'd0);

        // Writeback write
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("wb5_stall", 32'(wb_stall), 32'd0);
        idle();
        chk("wb5_we",   32'(rf_write_enable),  32'd1);
        chk("wb5_addr", 32'(rf_write_address), 32'd5);
        chk("wb5_data", rf_write_data,         32'hDEADBEEF);

        // Multicycle write on an idle writeback
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        chk("mc7_ready", 32'(mc_ready), 32'd1);
        idle();
        chk("mc7_addr", 32'(rf_write_address), 32'd7);
        chk("mc7_data", rf_write_data,         32'h1234);

        // Starvation: four writeback grants, then one forced multicycle grant
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 5'(10 + k), 32'(k), 1'b1, 5'd3, 32'hAAAA0000, 1'b0, 5'd0);
            chk("starve_mc_ready", 32'(mc_ready), 32'd0);
        end
        step(1'b0, 1'b1, 5'd14, 32'h14, 1'b1, 5'd3, 32'hAAAA0000, 1'b0, 5'd0);
        chk("force_mc_ready", 32'(mc_ready), 32'd1);
        chk("force_wb_stall", 32'(wb_stall), 32'd1);
        step(1'b0, 1'b1, 5'd15, 32'h15, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("force_wr_addr",   32'(rf_write_address), 32'd3);
        chk("force_wr_data",   rf_write_data,         32'hAAAA0000);
        chk("after_mc_ready",  32'(mc_ready),         32'd0);
        chk("after_wb_stall",  32'(wb_stall),         32'd0);
        idle();
        chk("after_wb_addr", 32'(rf_write_address), 32'd15);

        // Busy scoreboard set, clear, and same-cycle set-over-clear
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        idle();
        chk("busy_set9", busy_mask, 32'h200);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0);
        idle();
        chk("busy_clr9", busy_mask, 32'h0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h66, 1'b1, 5'd9);
        idle();
        chk("busy_setwins", busy_mask, 32'h200);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0);
        idle();
        chk("busy_clr9b", busy_mask, 32'h0);

        // Register 0: write suppressed, never busy
        step(1'b0, 1'b1, 5'd0, 32'hCAFE, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        idle();
        chk("r0_we",   32'(rf_write_enable), 32'd0);
        chk("r0_busy", busy_mask,            32'd0);

        // Reset while in FORCE with register 7 busy
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b1, 5'(20 + k), 32'(k), 1'b1, 5'd2, 32'hBEEF, 1'b0, 5'd0);
        step(1'b1, 1'b1, 5'd24, 32'h24, 1'b1, 5'd2, 32'hBEEF, 1'b0, 5'd0);
        chk("rstf_busy_before", busy_mask,     32'h80);
        chk("rstf_in_force",    32'(wb_stall), 32'd1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hBEEF, 1'b0, 5'd0);
        chk("rstf_we",       32'(rf_write_enable), 32'd0);
        chk("rstf_busy",     busy_mask,            32'd0);
        chk("rstf_mc_ready", 32'(mc_ready),        32'd1);
        idle();
        chk("rstf_readd", 32'(rf_write_address), 32'd2);

        // Random traffic; the multicycle request is held until accepted
        pend = 1'b0;
        pa   = '0;
        pd   = '0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) == 0);
            if (!pend && $urandom_range(0, 99) < 40) begin
                pend = 1'b1;
                pa   = 5'($urandom_range(0, 7));
                pd   = $urandom;
            end
            step(r, ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom,
                 pend, pa, pd, ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)));
            if (r || m_last_hs) pend = 1'b0;
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
